register_file_2w_sb: RTL and testbench
======================================

Name: register_file_2w_sb

Overview:
- Parametrised successor to the single-write-port integer register file.
- Provides: configurable XLEN and register count; two read ports; two write ports with a defined priority; write-to-read bypass; an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard (set on issue, cleared on writeback) so the decode stage can detect RAW hazards.
- Sits between decode (read and scoreboard set) and writeback (write and scoreboard clear) in the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), address width (derived; do not override).
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and busy-set.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_addr_i  in  ADDR_W  read port 1 address.
- rs2_addr_i  in  ADDR_W  read port 2 address.
- rs1_o  out  XLEN  read port 1 data (combinational, bypassed).
- rs2_o  out  XLEN  read port 2 data (combinational, bypassed).
- rs1_busy_o  out  1  scoreboard bit for rs1_addr_i, after bypass.
- rs2_busy_o  out  1  scoreboard bit for rs2_addr_i, after bypass.
- wr0_enable_i  in  1  write port 0 enable (older instruction).
- wr0_addr_i  in  ADDR_W  write port 0 address.
- wr0_data_i  in  XLEN  write port 0 data.
- wr1_enable_i  in  1  write port 1 enable (younger instruction).
- wr1_addr_i  in  ADDR_W  write port 1 address.
- wr1_data_i  in  XLEN  write port 1 data.
- set_busy_i  in  1  mark set_addr_i busy (instruction issued with destination).
- set_addr_i  in  ADDR_W  register to mark busy.

Behaviour:
Reset
- When reset is 1 at a rising edge, all registers become 0 and all busy bits become 0.
- Writes and busy-sets in that cycle are ignored.
- Reset dominates every other input.
- rs*_o and rs*_busy_o follow from the cleared state in the next cycle.
- There is no reset-time read hold.

Writes (rising edge, reset=0)
- An enabled port writes its data to its address.
- If both ports are enabled with the same address, port 1's data is stored (port 1 wins).
- If ZERO_REG=1 and the address is 0, the write is dropped.

Reads (combinational)
- Result for an address is chosen in this priority order:
  - ZERO_REG=1 and address 0 gives 0.
  - Else, wr1_enable_i with matching wr1_addr_i gives wr1_data_i.
  - Else, wr0_enable_i with matching wr0_addr_i gives wr0_data_i.
  - Else, the stored value.
- Bypass gives zero effective write-to-read latency: same-cycle visibility.
- Both read ports may address the same register and return identical data.

Scoreboard (busy[NUM_REGS], one bit per register)
- Edge update: first, busy[wrN_addr_i] is cleared for each enabled write port; then busy[set_addr_i] is set if set_busy_i=1.
- Set wins over a clear to the same address in the same cycle, because a new producer supersedes the completing one.
- With ZERO_REG=1, busy[0] is held at 0.
- rsN_busy_o = busy[addr] AND NOT (a write enabled this cycle to that addr).
- Writeback bypass therefore clears the hazard in the same cycle.
- set_busy_i does NOT affect rsN_busy_o until the following cycle.
- A write to a non-busy register is legal; it updates data, and busy stays 0.

Width rules
- Addresses are used modulo NUM_REGS; no out-of-range case exists.
- Data is stored unmodified.

Test Plan:
1. Reset: assert reset for 2 cycles after writing 0xDEADBEEF to r5 -> r5 reads 0x00000000 and all busy reads 0; a write presented during reset is dropped.
2. Dual write, distinct addresses: wr0 (r3, 0x11111111) and wr1 (r7, 0x22222222) in the same cycle -> next cycle rs1=r3 gives 0x11111111 and rs2=r7 gives 0x22222222.
3. Same-address conflict: wr0 (r9, 0xAAAAAAAA) and wr1 (r9, 0x55555555) -> bypassed rs1 reads 0x55555555 that cycle; the stored value is 0x55555555.
4. Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0 and set_busy r0 -> rs1=r0 reads 0 and rs1_busy_o=0 in all cycles.
5. Scoreboard lifecycle on r12:
   - set_busy r12 -> next cycle rs2_busy_o=1.
   - In the cycle wr0 writes r12 with 0x0000ABCD -> rs2_busy_o=0 and rs2_o=0x0000ABCD.
   - The cycle after -> still 0.
6. Set/clear collision: r4 busy; in one cycle wr1 writes r4 (0x1234) and set_busy targets r4 -> that cycle rs1_busy_o=0 and rs1_o=0x1234; the next cycle rs1_busy_o=1.
7. Sweep: write $random to all 32 registers over 32 cycles, then read them back on both ports with XLEN=32 and XLEN=64 builds -> all match the expected array (r0=0).

Source files
------------

// File: rtl/register_file_2w_sb.sv
// Two-read / two-write integer register file with same-cycle write bypass and a
// per-register busy scoreboard used by decode to spot RAW hazards.

module register_file_2w_sb_rd #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   stored,
  input  logic              busy,
  input  logic              wr0_enable,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [XLEN-1:0]   wr0_data,
  input  logic              wr1_enable,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [XLEN-1:0]   wr1_data,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_busy
);
  logic hit0, hit1;

  assign hit0 = wr0_enable && (wr0_addr == addr);
  assign hit1 = wr1_enable && (wr1_addr == addr);

  // Port 1 is the younger instruction, so its data shadows port 0.
  always_comb begin
    rd_data = stored;
    if ((ZERO_REG != 0) && (addr == '0)) rd_data = '0;
    else if (hit1)                        rd_data = wr1_data;
    else if (hit0)                        rd_data = wr0_data;
  end

  assign rd_busy = busy & ~(hit0 | hit1);
endmodule

module register_file_2w_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_o,
  output logic [XLEN-1:0]   rs2_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              wr0_enable_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [XLEN-1:0]   wr0_data_i,
  input  logic              wr1_enable_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [XLEN-1:0]   wr1_data_i,
  input  logic              set_busy_i,
  input  logic [ADDR_W-1:0] set_addr_i
);
  localparam int NUM_RD = 2;

  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [NUM_REGS-1:0]           busy, busy_nxt;

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]             rd_busy;

  // Clears first, then set: a newly issued producer supersedes the completing one.
  always_comb begin
    busy_nxt = busy;
    if (wr0_enable_i) busy_nxt[wr0_addr_i] = 1'b0;
    if (wr1_enable_i) busy_nxt[wr1_addr_i] = 1'b0;
    if (set_busy_i)   busy_nxt[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (wr0_enable_i) regs[wr0_addr_i] <= wr0_data_i;
      if (wr1_enable_i) regs[wr1_addr_i] <= wr1_data_i;
      if (ZERO_REG != 0) regs[0] <= '0;
    end
  end

  assign rd_addr = {rs2_addr_i, rs1_addr_i};

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      register_file_2w_sb_rd #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
      ) u_rd (
        .addr       (rd_addr[g]),
        .stored     (regs[rd_addr[g]]),
        .busy       (busy[rd_addr[g]]),
        .wr0_enable (wr0_enable_i),
        .wr0_addr   (wr0_addr_i),
        .wr0_data   (wr0_data_i),
        .wr1_enable (wr1_enable_i),
        .wr1_addr   (wr1_addr_i),
        .wr1_data   (wr1_data_i),
        .rd_data    (rd_data[g]),
        .rd_busy    (rd_busy[g])
      );
    end
  endgenerate

  assign rs1_o      = rd_data[0];
  assign rs2_o      = rd_data[1];
  assign rs1_busy_o = rd_busy[0];
  assign rs2_busy_o = rd_busy[1];
endmodule

// File: tb/tb_register_file_2w_sb.sv
// Bench for register_file_2w_sb: 32- and 64-bit builds driven in lockstep from a
// vector table, with expected read results queued and checked each cycle.

module tb_register_file_2w_sb;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          w0e, w1e, sb;
  logic [AW-1:0] w0a, w1a, sa, r1a, r2a;
  logic [63:0]   w0d, w1d;
  logic [31:0]   rs1_32, rs2_32;
  logic [63:0]   rs1_64, rs2_64;
  logic          b1_32, b2_32, b1_64, b2_64;

  always #5 clk = ~clk;

  register_file_2w_sb #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1)) u_dut32 (
    .clk(clk), .reset(reset),
    .rs1_addr_i(r1a), .rs2_addr_i(r2a),
    .rs1_o(rs1_32), .rs2_o(rs2_32), .rs1_busy_o(b1_32), .rs2_busy_o(b2_32),
    .wr0_enable_i(w0e), .wr0_addr_i(w0a), .wr0_data_i(w0d[31:0]),
    .wr1_enable_i(w1e), .wr1_addr_i(w1a), .wr1_data_i(w1d[31:0]),
    .set_busy_i(sb), .set_addr_i(sa)
  );

  register_file_2w_sb #(.XLEN(64), .NUM_REGS(32), .ZERO_REG(1)) u_dut64 (
    .clk(clk), .reset(reset),
    .rs1_addr_i(r1a), .rs2_addr_i(r2a),
    .rs1_o(rs1_64), .rs2_o(rs2_64), .rs1_busy_o(b1_64), .rs2_busy_o(b2_64),
    .wr0_enable_i(w0e), .wr0_addr_i(w0a), .wr0_data_i(w0d),
    .wr1_enable_i(w1e), .wr1_addr_i(w1a), .wr1_data_i(w1d),
    .set_busy_i(sb), .set_addr_i(sa)
  );

  typedef struct {
    string         name;
    logic          rst;
    logic          w0e;
    logic [AW-1:0] w0a;
    logic [63:0]   w0d;
    logic          w1e;
    logic [AW-1:0] w1a;
    logic [63:0]   w1d;
    logic          sb;
    logic [AW-1:0] sa;
    logic [AW-1:0] r1a, r2a;
    logic [63:0]   e1, e2;
    logic          eb1, eb2;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] e1, e2;
    logic        eb1, eb2;
  } exp_t;

  exp_t  sbq[$];
  vec_t  vecs[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic rst,
      input logic e0, input logic [AW-1:0] a0, input logic [63:0] d0,
      input logic e1_, input logic [AW-1:0] a1, input logic [63:0] d1,
      input logic s, input logic [AW-1:0] sad,
      input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
      input logic [63:0] x1, input logic [63:0] x2, input logic xb1, input logic xb2);
    vec_t v;
    v.name = n; v.rst = rst;
    v.w0e = e0; v.w0a = a0; v.w0d = d0;
    v.w1e = e1_; v.w1a = a1; v.w1d = d1;
    v.sb = s; v.sa = sad; v.r1a = ra1; v.r2a = ra2;
    v.e1 = x1; v.e2 = x2; v.eb1 = xb1; v.eb2 = xb2;
    return v;
  endfunction

  // Drives one cycle of stimulus just after the edge; expected outputs for that
  // cycle are queued and checked at the following falling edge.
  task automatic drive(input vec_t v, input bit check);
    exp_t e;
    @(posedge clk); #1;
    reset = v.rst;
    w0e = v.w0e; w0a = v.w0a; w0d = v.w0d;
    w1e = v.w1e; w1a = v.w1a; w1d = v.w1d;
    sb = v.sb; sa = v.sa; r1a = v.r1a; r2a = v.r2a;
    if (check) begin
      e.name = v.name; e.e1 = v.e1; e.e2 = v.e2; e.eb1 = v.eb1; e.eb2 = v.eb2;
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.name, " rs1_32"}, {32'h0, rs1_32}, {32'h0, e.e1[31:0]});
      chk({e.name, " rs2_32"}, {32'h0, rs2_32}, {32'h0, e.e2[31:0]});
      chk({e.name, " rs1_64"}, rs1_64, e.e1);
      chk({e.name, " rs2_64"}, rs2_64, e.e2);
      chk({e.name, " busy1_32"}, {63'h0, b1_32}, {63'h0, e.eb1});
      chk({e.name, " busy2_32"}, {63'h0, b2_32}, {63'h0, e.eb2});
      chk({e.name, " busy1_64"}, {63'h0, b1_64}, {63'h0, e.eb1});
      chk({e.name, " busy2_64"}, {63'h0, b2_64}, {63'h0, e.eb2});
    end
  end

  localparam logic [63:0] D5  = 64'hCAFEF00D_DEADBEEF;
  localparam logic [63:0] D3  = 64'h01010101_11111111;
  localparam logic [63:0] D7  = 64'h02020202_22222222;
  localparam logic [63:0] DA  = 64'hA5A5A5A5_AAAAAAAA;
  localparam logic [63:0] D55 = 64'h5A5A5A5A_55555555;
  localparam logic [63:0] DF  = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] DC  = 64'h00000000_0000ABCD;
  localparam logic [63:0] D12 = 64'h00000000_00001234;
  localparam logic [63:0] D20 = 64'h00000055_00000055;

  logic [63:0] model [32];

  initial begin
    vec_t idle;
    reset = 1'b1;
    w0e = 0; w1e = 0; sb = 0; w0a = '0; w1a = '0; sa = '0; r1a = '0; r2a = '0;
    w0d = '0; w1d = '0;

    //                 name        rst w0e w0a w0d   w1e w1a w1d   sb sa  r1 r2  e1    e2    b1 b2
    vecs.push_back(mk("wr r5",     0, 1,  5, D5,   0,  0, 0,    0,  0,  5, 0,  D5,   0,    0, 0));
    vecs.push_back(mk("rst1",      1, 0,  0, 0,    1,  6, DF,   1,  5,  5, 5,  D5,   D5,   0, 0));
    vecs.push_back(mk("rst2",      1, 0,  0, 0,    0,  0, 0,    0,  0,  5, 5,  0,    0,    0, 0));
    vecs.push_back(mk("post rst",  0, 0,  0, 0,    0,  0, 0,    0,  0,  5, 6,  0,    0,    0, 0));
    vecs.push_back(mk("dual wr",   0, 1,  3, D3,   1,  7, D7,   0,  0,  3, 7,  D3,   D7,   0, 0));
    vecs.push_back(mk("dual rd",   0, 0,  0, 0,    0,  0, 0,    0,  0,  3, 7,  D3,   D7,   0, 0));
    vecs.push_back(mk("conflict",  0, 1,  9, DA,   1,  9, D55,  0,  0,  9, 9,  D55,  D55,  0, 0));
    vecs.push_back(mk("confl rd",  0, 0,  0, 0,    0,  0, 0,    0,  0,  9, 9,  D55,  D55,  0, 0));
    vecs.push_back(mk("r0 wr",     0, 1,  0, DF,   1,  0, DF,   1,  0,  0, 0,  0,    0,    0, 0));
    vecs.push_back(mk("r0 rd",     0, 0,  0, 0,    0,  0, 0,    0,  0,  0, 0,  0,    0,    0, 0));
    vecs.push_back(mk("set r12",   0, 0,  0, 0,    0,  0, 0,    1, 12,  0, 12, 0,    0,    0, 0));
    vecs.push_back(mk("r12 busy",  0, 0,  0, 0,    0,  0, 0,    0,  0, 12, 12, 0,    0,    1, 1));
    vecs.push_back(mk("r12 wb",    0, 1, 12, DC,   0,  0, 0,    0,  0,  0, 12, 0,    DC,   0, 0));
    vecs.push_back(mk("r12 after", 0, 0,  0, 0,    0,  0, 0,    0,  0,  0, 12, 0,    DC,   0, 0));
    vecs.push_back(mk("set r4",    0, 0,  0, 0,    0,  0, 0,    1,  4,  4, 0,  0,    0,    0, 0));
    vecs.push_back(mk("r4 busy",   0, 0,  0, 0,    0,  0, 0,    0,  0,  4, 0,  0,    0,    1, 0));
    vecs.push_back(mk("r4 coll",   0, 0,  0, 0,    1,  4, D12,  1,  4,  4, 0,  D12,  0,    0, 0));
    vecs.push_back(mk("r4 reset",  0, 0,  0, 0,    1, 20, D20,  0,  0,  4, 20, D12,  D20,  1, 0));
    vecs.push_back(mk("nonbusy",   0, 0,  0, 0,    0,  0, 0,    0,  0, 12, 20, DC,   D20,  0, 0));

    idle = mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle, 1'b0);
    drive(idle, 1'b0);
    foreach (vecs[i]) drive(vecs[i], 1'b1);

    // Sweep: fill every register through alternating ports, then read both ways.
    for (int i = 0; i < 32; i++) begin
      logic [63:0] val;
      vec_t v;
      val = {$urandom, $urandom};
      model[i] = (i == 0) ? 64'h0 : val;
      v = mk("sweep wr", 0, (i % 2) == 0, AW'(i), val, (i % 2) == 1, AW'(i), val,
             0, 0, AW'(i), AW'(i), model[i], model[i], 0, 0);
      drive(v, 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      vec_t v;
      v = mk("sweep rd", 0, 0, 0, 0, 0, 0, 0, 0, 0, AW'(i), AW'(31 - i),
             model[i], model[31 - i], 0, 0);
      drive(v, 1'b1);
    end
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    for (int k = 0; k < 4 && sbq.size() > 0; k++) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
